// File: rtl/ob_pkg.sv
// Shared order-book response types and framing constants for the egress path.
package ob_pkg;

    // Order-book engine response; this block treats it as an opaque 115-bit word.
    typedef struct packed {
        logic [31:0] order_id;
        logic [31:0] price;
        logic [31:0] qty;
        logic        side;
        logic [3:0]  status;
        logic [13:0] seq;
    } rsp_t;

    localparam int unsigned RSP_FRAME_BYTES_N = (($bits(rsp_t) + 7) / 8);

    typedef logic [RSP_FRAME_BYTES_N*8-1:0] rsp_frame_t;
    typedef logic [7:0]                     byte_t;

endpackage

// File: rtl/ob_rsp_serializer.sv
// Serialises one rsp_t per handshake into a fixed-length MSB-first byte frame
// with SOF/EOF markers; a 1-deep pending buffer allows bubble-free back-to-back frames.
module ob_rsp_serializer
    import ob_pkg::*;
#(
    parameter int unsigned FRAME_BYTES_N = 15
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  rsp_vld,
    input  rsp_t  rsp,
    output logic  rsp_accept,
    output logic  out_vld,
    output byte_t out_data,
    output logic  out_sof,
    output logic  out_eof,
    input  logic  out_accept,
    output logic  busy
);

    localparam int unsigned FRAME_W  = $bits(rsp_frame_t);
    localparam logic [3:0]  LAST_IDX = 4'(FRAME_BYTES_N - 1);

    if (FRAME_BYTES_N != RSP_FRAME_BYTES_N) begin : g_bad_frame_len
        $error("FRAME_BYTES_N must equal ceil($bits(rsp_t)/8)");
    end

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t     state_q, state_d;
    rsp_frame_t sr_q, sr_d;
    logic [3:0] cnt_q, cnt_d;
    rsp_t       pend_q, pend_d;
    logic       pend_vld_q, pend_vld_d;

    logic rsp_hs;
    logic byte_hs;
    logic last_byte;

    // Output decode straight from registered state so everything is glitch-free.
    always_comb begin
        rsp_accept = ~pend_vld_q;
        out_vld    = (state_q == ST_SEND);
        out_data   = sr_q[FRAME_W-1 -: 8];
        out_sof    = out_vld & (cnt_q == 4'd0);
        out_eof    = out_vld & (cnt_q == LAST_IDX);
        busy       = out_vld | pend_vld_q;
    end

    // Next-state logic for the frame shifter, byte index and pending buffer.
    always_comb begin
        rsp_hs     = rsp_vld & rsp_accept;
        byte_hs    = out_vld & out_accept;
        last_byte  = (cnt_q == LAST_IDX);
        state_d    = state_q;
        sr_d       = sr_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;

        unique case (state_q)
            ST_IDLE: begin
                if (rsp_hs) begin
                    sr_d    = rsp_frame_t'(rsp);
                    cnt_d   = '0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (rsp_hs) begin
                    pend_d     = rsp;
                    pend_vld_d = 1'b1;
                end
                if (byte_hs) begin
                    if (!last_byte) begin
                        sr_d  = {sr_q[FRAME_W-9:0], 8'h00};
                        cnt_d = cnt_q + 4'd1;
                    end else if (pend_vld_q) begin
                        sr_d       = rsp_frame_t'(pend_q);
                        cnt_d      = '0;
                        pend_vld_d = 1'b0;
                    end else if (rsp_hs) begin
                        // A response arriving on the EOF handshake bypasses the
                        // pending buffer and becomes the next frame directly.
                        sr_d       = rsp_frame_t'(rsp);
                        cnt_d      = '0;
                        pend_vld_d = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset discards any frame in flight and the pending entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            sr_q       <= '0;
            cnt_q      <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
        end
    end

endmodule

// File: tb/tb_ob_rsp_serializer.sv
// Directed self-checking bench for ob_rsp_serializer with a byte scoreboard.
module tb_ob_rsp_serializer;
    import ob_pkg::*;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    logic  rsp_vld = 1'b0;
    rsp_t  rsp = '0;
    logic  rsp_accept;
    logic  out_vld;
    byte_t out_data;
    logic  out_sof;
    logic  out_eof;
    logic  out_accept = 1'b1;
    logic  busy;

    ob_rsp_serializer #(.FRAME_BYTES_N(15)) dut (
        .clk        (clk),
        .rst        (rst),
        .rsp_vld    (rsp_vld),
        .rsp        (rsp),
        .rsp_accept (rsp_accept),
        .out_vld    (out_vld),
        .out_data   (out_data),
        .out_sof    (out_sof),
        .out_eof    (out_eof),
        .out_accept (out_accept),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       sof;
        logic       eof;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   delivered = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected frame image is {5'b0, rsp}, byte 0 = bits 119:112.
    task automatic push_frame(input rsp_t r);
        logic [119:0] img;
        img = {5'b0, r};
        for (int k = 0; k < 15; k++) begin
            exp_q.push_back('{data: img[119-8*k -: 8], sof: (k == 0), eof: (k == 14)});
        end
    endtask

    // Present r until accepted; inputs change #1 after posedge, sampled at negedge.
    task automatic offer(input rsp_t r);
        bit done;
        done = 0;
        rsp_vld = 1'b1;
        rsp = r;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (rsp_accept === 1'b1) begin
                push_frame(r);
                done = 1;
            end
            @(posedge clk); #1;
        end
        rsp_vld = 1'b0;
        if (!done) chk("offer_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_idle();
        bit done;
        done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (busy === 1'b0) done = 1;
        end
        if (!done) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    // Monitor: pop scoreboard on every byte handshake; check stall stability.
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data;
    logic       prev_sof, prev_eof;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && out_vld) begin
                chk("stall_data", 32'(out_data), 32'(prev_data));
                chk("stall_sof", 32'(out_sof), 32'(prev_sof));
                chk("stall_eof", 32'(out_eof), 32'(prev_eof));
            end
            if (out_vld === 1'b1 && out_accept === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_byte", 32'(out_data), 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("byte_data", 32'(out_data), 32'(e.data));
                    chk("byte_sof", 32'(out_sof), 32'(e.sof));
                    chk("byte_eof", 32'(out_eof), 32'(e.eof));
                end
                delivered++;
            end
            prev_stall = out_vld && !out_accept;
            prev_data  = out_data;
            prev_sof   = out_sof;
            prev_eof   = out_eof;
        end
    end

    initial begin
        rsp_t ones, one, ra, rb;
        int   run, base;
        bit   done;
        logic [114:0] tmp;
        ones = '1;
        tmp = 115'd1;
        one = tmp;
        tmp = {$urandom, $urandom, $urandom, $urandom};
        ra = tmp;
        tmp = {$urandom, $urandom, $urandom, $urandom};
        rb = tmp;

        // Reset state
        #1;
        chk("rst_out_vld", 32'(out_vld), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_accept", 32'(rsp_accept), 32'd1);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_sof_eof", {30'd0, out_sof, out_eof}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Single frame, all-ones: 1-cycle latency, 15 valid cycles, then idle
        @(posedge clk); #1;
        offer(ones);
        @(negedge clk);
        chk("t1_first_vld", 32'(out_vld), 32'd1);
        chk("t1_first_sof", 32'(out_sof), 32'd1);
        run = 1;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (out_vld === 1'b1) run++;
        end
        chk("t1_valid_cycles", 32'(run), 32'd15);
        @(negedge clk);
        chk("t1_vld_drop", 32'(out_vld), 32'd0);
        chk("t1_busy_drop", 32'(busy), 32'd0);

        // LSB-only frame
        @(posedge clk); #1;
        offer(one);
        wait_idle();
        chk("t2_sb_empty", 32'(exp_q.size()), 32'd0);

        // Back-to-back: B into pend during A, no gap between frames
        @(posedge clk); #1;
        offer(ones);
        offer(one);
        run = 0;
        done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (i < 14) chk("t3_accept_low", 32'(rsp_accept), 32'd0);
            if (i == 14) chk("t3_accept_reopen", 32'(rsp_accept), 32'd1);
            if (out_vld === 1'b1) run++;
            else done = 1;
        end
        // cycles 2..30 counted here; cycle 1 was spent inside offer(B)
        chk("t3_consecutive", 32'(run), 32'd29);
        wait_idle();
        chk("t3_sb_empty", 32'(exp_q.size()), 32'd0);

        // Backpressure 1,0,0,1 pattern during a frame
        @(posedge clk); #1;
        base = delivered;
        offer(ra);
        for (int i = 0; i < 80 && (delivered - base) < 15; i++) begin
            out_accept = (i % 4 == 0) || (i % 4 == 3);
            @(posedge clk); #1;
        end
        out_accept = 1'b1;
        wait_idle();
        chk("t4_delivered", 32'(delivered - base), 32'd15);
        chk("t4_sb_empty", 32'(exp_q.size()), 32'd0);

        // Collision: B offered exactly on A's EOF handshake with pend empty
        @(posedge clk); #1;
        offer(rb);
        done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (out_vld === 1'b1 && out_eof === 1'b1) done = 1;
        end
        chk("t5_found_eof", 32'(done), 32'd1);
        #1;
        rsp_vld = 1'b1;
        rsp = ones;
        #1;
        chk("t5_accept_on_eof", 32'(rsp_accept), 32'd1);
        if (rsp_accept === 1'b1) push_frame(ones);
        @(posedge clk); #1;
        rsp_vld = 1'b0;
        @(negedge clk);
        chk("t5_next_vld", 32'(out_vld), 32'd1);
        chk("t5_next_sof", 32'(out_sof), 32'd1);
        chk("t5_pend_empty", 32'(rsp_accept), 32'd1);
        wait_idle();
        chk("t5_sb_empty", 32'(exp_q.size()), 32'd0);

        // Async reset at byte 7 with pend full
        @(posedge clk); #1;
        base = delivered;
        offer(ra);
        offer(rb);
        for (int i = 0; i < 40 && (delivered - base) < 7; i++) begin
            @(posedge clk); #1;
        end
        chk("t6_reached_byte7", 32'(delivered - base), 32'd7);
        chk("t6_pend_full", 32'(rsp_accept), 32'd0);
        #2;
        exp_q.delete();
        rst = 1'b1;
        #1;
        chk("t6_async_vld", 32'(out_vld), 32'd0);
        chk("t6_async_busy", 32'(busy), 32'd0);
        chk("t6_async_accept", 32'(rsp_accept), 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        run = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_vld !== 1'b0 || rsp_accept !== 1'b1) run++;
        end
        chk("t6_no_stale", 32'(run), 32'd0);

        chk("end_sb_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ob_rsp_serializer.md
Name: ob_rsp_serializer

Overview:
Egress stage directly downstream of the order-book response path. Accepts one ob_pkg::rsp_t per valid/accept handshake and emits it as a fixed-length, MSB-first byte stream with start-of-frame (SOF) and end-of-frame (EOF) markers, for the host link.
A 1-deep pending buffer lets the engine hand over the next response while the current frame drains, so back-to-back frames have no bubble.

Parameters:
FRAME_BYTES_N, 15, bytes per frame; must equal ceil($bits(ob_pkg::rsp_t)/8) (115b -> 15), elaboration-time check.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
rsp_vld  in  1  response valid from engine
rsp  in  $bits(ob_pkg::rsp_t)  response payload
rsp_accept  out  1  response accepted this cycle when rsp_vld & rsp_accept
out_vld  out  1  byte valid
out_data  out  8  byte payload
out_sof  out  1  first byte of frame (qualified by out_vld)
out_eof  out  1  last byte of frame (qualified by out_vld)
out_accept  in  1  downstream takes byte when out_vld & out_accept
busy  out  1  frame in flight or pending buffer occupied

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-high, port names clk and rst.
- Frame image: 120b = {5'b0, rsp}. Byte k (k = 0..14) = image[119-8k -: 8]; byte 0 is sent first.
- State: IDLE, SEND. Registers:
  - sr[119:0]: shift register.
  - cnt[3:0]: byte index.
  - pend (rsp_t) and pend_vld.
- Reset values: state = IDLE, cnt = 0, pend_vld = 0, sr = 0. Outputs: out_vld = 0, out_sof = 0, out_eof = 0, busy = 0, out_data = 0.
- rsp_accept = ~pend_vld, combinational. It is 1 after reset.
- out_vld = (state == SEND). out_data = sr[119:112]. out_sof = out_vld & (cnt == 0). out_eof = out_vld & (cnt == 14).
- IDLE, on rsp handshake: sr <= image, cnt <= 0, state <= SEND. First out_vld appears on the next cycle (1-cycle latency). pend is not used.
- SEND, byte handshake with cnt < 14: sr <= sr << 8, cnt <= cnt + 1.
- SEND, no handshake: sr, cnt and all outputs hold. out_data must not change while out_vld & ~out_accept.
- SEND, rsp handshake: pend <= rsp, pend_vld <= 1.
- SEND, last byte handshake (cnt == 14):
  - If pend_vld: sr <= {5'b0, pend}, cnt <= 0, pend_vld <= 0, stay in SEND. The next cycle presents the SOF byte of the next frame (zero bubble).
  - Else if an rsp handshake occurs in the same cycle: load sr directly from rsp, cnt <= 0, stay in SEND. pend stays empty.
  - Else: state <= IDLE.
- Simultaneous rsp handshake and last-byte handshake while pend_vld = 1 cannot occur, because rsp_accept = 0.
- busy = (state == SEND) | pend_vld.
- Reset mid-frame: the frame and pend are discarded immediately. No partial-frame completion and no EOF is emitted.
- rsp contents are opaque to this block. No field decoding, no status filtering.

Decomposition:
- In ob_pkg: localparam RSP_FRAME_BYTES_N = (($bits(rsp_t)+7)/8); typedef logic [RSP_FRAME_BYTES_N*8-1:0] rsp_frame_t; typedef logic [7:0] byte_t.
- State enum is local to the module.
- No sub-module is needed. Single module, about 150 lines.

Test Plan:
- Single frame, rsp = all-ones, out_accept = 1 -> rsp_vld at cycle 0, out_vld at cycles 1..15. Bytes are 0x07, then 0xFF x14. sof at byte 0, eof at byte 14. busy falls at cycle 16.
- rsp = 1 (LSB only) -> bytes 0..13 = 0x00, byte 14 = 0x01.
- Back-to-back, rsp A = all-ones then rsp B = 1, offered continuously:
  - B is accepted into pend during A.
  - rsp_accept = 0 until A's EOF handshake.
  - B's SOF byte follows A's EOF with no gap: 30 consecutive valid cycles.
- Backpressure: out_accept toggles 1,0,0,1,... during frame A -> out_data and sof/eof are stable while stalled. Exactly 15 bytes are delivered, in order, and match the expected frame.
- Last-byte/accept collision with pend empty: rsp B is presented exactly on A's EOF handshake cycle -> B is accepted. The next cycle is B's SOF; pend_vld stays 0.
- Reset asserted asynchronously at byte 7 with pend full -> out_vld, busy and pend_vld drop without waiting for a clock edge. After release, rsp_accept = 1 and no stale bytes appear.
